butterfly_pipe: RTL
===================

// Module: butterfly_pipe
// PURPOSE
//  Pipelined, parametrised radix-2 DIT butterfly: q_a = A + B*W', q_b = A - B*W'.
//  Forward mode uses W' = conj(W); inverse mode uses W' = W. Adds valid/ready flow control,
//  rounding, optional 1/2 per-stage scaling, output saturation and a sticky overflow flag.
//  Sits between the FFT memory sequencer and data RAM; the twiddle arrives on a port from the external twiddle ROM.
// PARAMETERS
//  DW    32  width of each real/imag data component (signed, two's complement)
//  TW    32  width of each real/imag twiddle component (signed, Q(TW-FRAC-1).FRAC)
//  FRAC  16  twiddle fraction bits; product is shifted right by FRAC after rounding
//  SAT   1   1: saturate outputs to DW bits; 0: wrap (overflow flag still computed)
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous active-low reset
//  in_valid  in   1      input beat valid
//  in_ready  out  1      block accepts beat when in_valid && in_ready
//  inverse   in   1      per-beat mode: 0 forward (B*conj W), 1 inverse (B*W)
//  scale     in   1      per-beat: 1 = outputs divided by 2 with rounding
//  data_a    in   2*DW   {Re,Im} operand A
//  data_b    in   2*DW   {Re,Im} operand B
//  w_in      in   2*TW   {Re,Im} twiddle, aligned with data_b
//  out_valid out  1      result valid
//  out_ready in   1      downstream accepts result
//  q_a       out  2*DW   {Re,Im} A + B*W'
//  q_b       out  2*DW   {Re,Im} A - B*W'
//  ovf       out  1      sticky: any saturated/wrapped output component since clear
//  ovf_clr   in   1      synchronous clear of ovf (clear wins over same-cycle set)
// BEHAVIOUR
//  - Reset: all stage valids 0, out_valid 0, q_a/q_b 0, ovf 0; in_ready 1 after reset release.
//  - Global advance: adv = !out_valid || out_ready; in_ready = adv. All stages move only on adv.
//  - Latency 4 accepted-cycles: S1 register A,B,W,mode; S2 four DW x TW products (DW+TW bits);
//    S3 combine: fwd Re=bRe*wRe+bIm*wIm, Im=bIm*wRe-bRe*wIm; inv Re=bRe*wRe-bIm*wIm,
//    Im=bIm*wRe+bRe*wIm; add 2^(FRAC-1), arithmetic shift right FRAC -> T (DW+1 bits, no truncation);
//    S4 A+/-T in DW+2 bits; if scale: (x+1)>>>1; then saturate/wrap to DW -> q_a/q_b, out_valid.
//  - Throughput 1 beat/cycle while out_ready=1; stalls hold every stage bit-exact; bubbles
//    (in_valid=0) propagate as valid=0 and never raise out_valid.
//  - out_valid/q_* stable while out_valid && !out_ready (no output change under stall).
//  - Saturation: >2^(DW-1)-1 -> 0x7F..F, < -2^(DW-1) -> 0x80..0; sets ovf only on a beat with
//    stage-4 valid and adv; applies to each of 4 components independently.
//  - ovf_clr and set in the same cycle: ovf = 0.
//  - Reset asserted mid-stream: all in-flight beats discarded, no out_valid after release until
//    4 accepted beats later.
//  - W = -1.0 exactly (TW min) is legal; product widths sized so no internal overflow occurs.
// STRUCTURE
//  - fft_pkg: default DW/TW/FRAC, function sat_dw(), {Re,Im} pack/unpack helpers, LAT=4 constant.
//  - Sub-module cmult_rnd (stages S2-S3): complex multiply with conj select, round, shift;
//    reused later by the radix-4 unit. Stage S1/S4, handshake and ovf live in butterfly_pipe.
// TESTING (DW=32, TW=32, FRAC=16, SAT=1; W=1.0 is wRe=65536)
//  - A=(100,50) B=(10,-4) W=(65536,0) fwd, scale=0 -> 4 cycles later q_a=(110,46) q_b=(90,54).
//  - Same A,B, W=(0,65536): fwd -> q_a=(96,40) q_b=(104,60); inverse -> q_a=(104,60) q_b=(96,40).
//  - Rounding: A=0 B=(1,0) W=(32768,0) -> T=(1,0), q_a=(1,0) q_b=(-1,0); scale=1 on A=(100,50),
//    B=(10,-4), W=1.0 -> q_a=(55,23) q_b=(45,27).
//  - Saturation: A=(0x7FFFFFFF,0) B=(1,0) W=1.0 -> q_a.Re=0x7FFFFFFF, q_b.Re=0x7FFFFFFE, ovf=1
//    next cycle; ovf_clr pulse -> ovf=0.
//  - Back-pressure: 8 back-to-back beats, out_ready low for cycles 5-7 -> in_ready low same
//    cycles, no beat lost/duplicated, results in order and match golden model.
//  - Reset mid-stream with 3 beats in flight -> outputs 0, out_valid 0, no stale beat emerges.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg
//   Shared definitions for the FFT datapath blocks.
//   - DEF_DW / DEF_TW / DEF_FRAC : default data width, twiddle width, twiddle fraction bits
//   - LAT                        : butterfly latency in accepted cycles
//   - mode_e                     : per-beat butterfly direction (forward uses conj(W))
//   - sat_dw()                   : saturate or wrap a wide signed value to dw bits and flag overflow
//   - pack_c / re_of / im_of     : {Re,Im} pack/unpack helpers at the default data width
package fft_pkg;

    localparam int DEF_DW   = 32;
    localparam int DEF_TW   = 32;
    localparam int DEF_FRAC = 16;
    localparam int LAT      = 4;

    // Working width of sat_dw(); wide enough for a DW+2 bit sum with DW up to 64.
    localparam int SAT_W = 66;
    localparam int VW    = SAT_W - 2;

    typedef enum logic {
        MODE_FWD = 1'b0,
        MODE_INV = 1'b1
    } mode_e;

    typedef struct packed {
        logic [VW-1:0] val;
        logic          ovf;
    } sat_t;

    // The overflow flag is raised whether or not clamping is enabled, so
    // wrap mode still reports that the result left the dw-bit range.
    function automatic sat_t sat_dw(input logic signed [SAT_W-1:0] x,
                                    input int                      dw,
                                    input logic                    sat_en);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_t                    r;
        hi    = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
        lo    = ~hi;
        r.ovf = (x > hi) || (x < lo);
        if (sat_en && (x > hi))
            r.val = VW'(hi);
        else if (sat_en && (x < lo))
            r.val = VW'(lo);
        else
            r.val = VW'(x);
        return r;
    endfunction

    function automatic logic [2*DEF_DW-1:0] pack_c(input logic [DEF_DW-1:0] re,
                                                   input logic [DEF_DW-1:0] im);
        return {re, im};
    endfunction

    function automatic logic [DEF_DW-1:0] re_of(input logic [2*DEF_DW-1:0] c);
        return c[2*DEF_DW-1:DEF_DW];
    endfunction

    function automatic logic [DEF_DW-1:0] im_of(input logic [2*DEF_DW-1:0] c);
        return c[DEF_DW-1:0];
    endfunction

endpackage

// File: rtl/butterfly_pipe_if.sv
// butterfly_pipe_if
//   Streaming bus of the butterfly: input beat (A, B, W, mode, scale) with
//   valid/ready and output beat (q_a, q_b) with valid/ready.
//   master : the side that produces input beats and consumes results (sequencer)
//   slave  : the butterfly itself
interface butterfly_pipe_if
    import fft_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int TW = DEF_TW
);
    logic            in_valid;
    logic            in_ready;
    logic            inverse;
    logic            scale;
    logic [2*DW-1:0] data_a;
    logic [2*DW-1:0] data_b;
    logic [2*TW-1:0] w_in;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] q_a;
    logic [2*DW-1:0] q_b;

    modport master (
        output in_valid, inverse, scale, data_a, data_b, w_in, out_ready,
        input  in_ready, out_valid, q_a, q_b
    );

    modport slave (
        input  in_valid, inverse, scale, data_a, data_b, w_in, out_ready,
        output in_ready, out_valid, q_a, q_b
    );
endinterface

// File: rtl/cmult_rnd.sv
// cmult_rnd
//   Two-stage complex multiply T = B * W' with rounding, W' = conj(W) in
//   forward mode and W in inverse mode.
//   Stage A registers the four partial products, stage B combines them,
//   adds half an LSB and shifts right by FRAC.
//   Ports: clk, rst_n (async active-low), en (pipeline advance),
//          in_valid/mode/b_re/b_im/w_re/w_im (stage inputs),
//          out_valid/t_re/t_im (DW+1 bit rounded product).
module cmult_rnd
    import fft_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int TW   = DEF_TW,
    parameter int FRAC = DEF_FRAC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    input  mode_e                mode,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    output logic                 out_valid,
    output logic signed [DW:0]   t_re,
    output logic signed [DW:0]   t_im
);
    // Full DW x TW products plus one carry bit for the sum, so even
    // B = W = most-negative cannot overflow before rounding.
    localparam int PW = DW + TW;
    localparam int SW = PW + 1;
    localparam int TWD = DW + 1;
    localparam logic signed [SW-1:0] RND = SW'(1) << (FRAC - 1);

    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    mode_e                mode2;
    logic                 v2;
    logic signed [SW-1:0] sum_re, sum_im, rnd_re, rnd_im;

    // Partial products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            mode2 <= MODE_FWD;
            p_rr  <= '0;
            p_ii  <= '0;
            p_ri  <= '0;
            p_ir  <= '0;
        end else if (en) begin
            v2    <= in_valid;
            mode2 <= mode;
            p_rr  <= PW'(b_re) * PW'(w_re);
            p_ii  <= PW'(b_im) * PW'(w_im);
            p_ri  <= PW'(b_re) * PW'(w_im);
            p_ir  <= PW'(b_im) * PW'(w_re);
        end
    end

    // Conjugating W only flips the sign of the wIm terms.
    always_comb begin
        sum_re = SW'(p_rr) + SW'(p_ii);
        sum_im = SW'(p_ir) - SW'(p_ri);
        if (mode2 == MODE_INV) begin
            sum_re = SW'(p_rr) - SW'(p_ii);
            sum_im = SW'(p_ir) + SW'(p_ri);
        end
        rnd_re = sum_re + RND;
        rnd_im = sum_im + RND;
    end

    // For twiddles with |W| <= 1 the shifted result always fits DW+1 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            t_re      <= '0;
            t_im      <= '0;
        end else if (en) begin
            out_valid <= v2;
            t_re      <= TWD'(rnd_re >>> FRAC);
            t_im      <= TWD'(rnd_im >>> FRAC);
        end
    end
endmodule

// File: rtl/butterfly_pipe.sv
// butterfly_pipe
//   Four-stage radix-2 DIT butterfly: q_a = A + B*W', q_b = A - B*W'.
//   S1 input register, S2-S3 complex multiply (cmult_rnd), S4 add/subtract,
//   optional rounded halving and saturation/wrap to DW bits.
//   Ports: clk, rst_n (async active-low), bus (butterfly_pipe_if.slave),
//          ovf (sticky overflow), ovf_clr (synchronous clear, wins over set).
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int TW   = DEF_TW,
    parameter int FRAC = DEF_FRAC,
    parameter int SAT  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    butterfly_pipe_if.slave        bus,
    input  logic                   ovf_clr,
    output logic                   ovf
);
    localparam int EW = DW + 2;
    localparam logic signed [EW-1:0] ONE = EW'(1);

    logic                 adv;
    logic                 out_valid_r;
    logic [2*DW-1:0]      q_a_r, q_b_r;

    logic                 v1;
    mode_e                mode1;
    logic                 sc1, sc2, sc3;
    logic signed [DW-1:0] a1_re, a1_im, a2_re, a2_im, a3_re, a3_im;
    logic signed [DW-1:0] b1_re, b1_im;
    logic signed [TW-1:0] w1_re, w1_im;

    logic                 v3;
    logic signed [DW:0]   t_re, t_im;

    logic signed [EW-1:0] pre [4];
    sat_t                 res [4];
    logic                 any_ovf;

    // One global advance: the whole pipe freezes while a result is held unread.
    assign adv           = !out_valid_r || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_r;
    assign bus.q_a       = q_a_r;
    assign bus.q_b       = q_b_r;

    // S1 plus the A/scale delay line that keeps A aligned with T at S4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            mode1 <= MODE_FWD;
            sc1   <= 1'b0;
            sc2   <= 1'b0;
            sc3   <= 1'b0;
            a1_re <= '0;
            a1_im <= '0;
            a2_re <= '0;
            a2_im <= '0;
            a3_re <= '0;
            a3_im <= '0;
            b1_re <= '0;
            b1_im <= '0;
            w1_re <= '0;
            w1_im <= '0;
        end else if (adv) begin
            v1    <= bus.in_valid;
            mode1 <= mode_e'(bus.inverse);
            sc1   <= bus.scale;
            a1_re <= bus.data_a[2*DW-1:DW];
            a1_im <= bus.data_a[DW-1:0];
            b1_re <= bus.data_b[2*DW-1:DW];
            b1_im <= bus.data_b[DW-1:0];
            w1_re <= bus.w_in[2*TW-1:TW];
            w1_im <= bus.w_in[TW-1:0];
            sc2   <= sc1;
            a2_re <= a1_re;
            a2_im <= a1_im;
            sc3   <= sc2;
            a3_re <= a2_re;
            a3_im <= a2_im;
        end
    end

    cmult_rnd #(
        .DW   (DW),
        .TW   (TW),
        .FRAC (FRAC)
    ) u_cmult (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (adv),
        .in_valid  (v1),
        .mode      (mode1),
        .b_re      (b1_re),
        .b_im      (b1_im),
        .w_re      (w1_re),
        .w_im      (w1_im),
        .out_valid (v3),
        .t_re      (t_re),
        .t_im      (t_im)
    );

    // DW+2 bits hold A +/- T exactly; (x+1)>>>1 is the rounded halving.
    always_comb begin
        pre[0] = EW'(a3_re) + EW'(t_re);
        pre[1] = EW'(a3_im) + EW'(t_im);
        pre[2] = EW'(a3_re) - EW'(t_re);
        pre[3] = EW'(a3_im) - EW'(t_im);
        for (int k = 0; k < 4; k++) begin
            if (sc3)
                pre[k] = (pre[k] + ONE) >>> 1;
            res[k] = sat_dw(SAT_W'(pre[k]), DW, SAT != 0);
        end
        any_ovf = res[0].ovf | res[1].ovf | res[2].ovf | res[3].ovf;
    end

    // S4 output register; results only change when a valid beat advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            q_a_r       <= '0;
            q_b_r       <= '0;
        end else if (adv) begin
            out_valid_r <= v3;
            if (v3) begin
                q_a_r <= {DW'(res[0].val), DW'(res[1].val)};
                q_b_r <= {DW'(res[2].val), DW'(res[3].val)};
            end
        end
    end

    // Sticky overflow; a same-cycle clear takes priority over a new event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (ovf_clr)
            ovf <= 1'b0;
        else if (adv && v3 && any_ovf)
            ovf <= 1'b1;
    end
endmodule
